mmio_fifo_afu: RTL and testbench
================================

# mmio_fifo_afu

Parametrised CCI-P MMIO accelerator function unit: a bank of host-writable user registers plus a show-ahead FIFO that the host pushes and pops through MMIO. It replaces the single-register MMIO AFU with a generalised, depth- and width-configurable version that adds:
- FIFO status reporting
- sticky overflow/underflow error flags
- flush control
- a non-destructive peek

It sits directly behind the platform's registered CCI-P shim, as the top-level `afu`-level block.

## Interface
- DATA_W, 64: FIFO entry width; 1..64; narrower data is zero-extended on read.
- DEPTH, 16: FIFO entries; power of two, ≥2.
- NUM_REGS, 4: user registers, 1..8.
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- rx  input  t_if_ccip_Rx  CCI-P receive.
  - c0.hdr is cast to t_ccip_c0_ReqMmioHdr.
  - Uses mmioWrValid, mmioRdValid and data.
- tx  output  t_if_ccip_Tx  CCI-P transmit.
  - Only c2 is driven.
  - c0/c1 hdr and valid are held 0.

## Operation
MMIO addresses are 32-bit-word addresses, and all registers are 64-bit at even addresses. Unlisted read addresses return 0; unlisted write addresses are ignored.

Read map:
- 0x0000: DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}.
- 0x0002 / 0x0004: AFU_ID low / high.
- 0x0006, 0x0008: 0.
- 0x0020 + 2*i: user_reg[i], i < NUM_REGS.
- 0x0044 POP: returns the head entry zero-extended and removes it.
  - If the FIFO is empty, returns 0, sets underflow, and count is unchanged.
- 0x0046 STATUS: {zeros, count[CW-1:0] at [15:4], overflow[3], underflow[2], full[1], empty[0]}.
  - CW = $clog2(DEPTH)+1.
- 0x0048 PEEK: returns the head entry (0 if empty) without popping.
- 0x0020+2*i is also readable back after writes.

Write map:
- 0x0020 + 2*i: user_reg[i] <= data.
- 0x0040 PUSH: pushes data[DATA_W-1:0] if not full.
  - If full, the data is dropped, overflow is set, and FIFO contents are unchanged.
- 0x0042 CTRL:
  - bit0 = flush: count → 0, pointers → 0.
  - bit1 = clear sticky flags.
  - Both bits may be set together.

General rules:
- Flags are sticky until CTRL bit1 or reset.
- count saturates at DEPTH by construction; pointers wrap modulo DEPTH.
- mmioWrValid and mmioRdValid are never asserted together (c0 carries one MMIO request per cycle). If they are, the write is serviced and the read is dropped.

## Timing
Reset values: all user_reg = 0, FIFO empty, pointers = 0, flags = 0, tx.c2.mmioRdValid = 0, tx.c2.hdr = 0, tx.c0/c1 = 0. tx.c2.data is reset to 0.

Reads:
- Read request at cycle N → tx.c2.mmioRdValid = 1 for exactly cycle N+1.
- tx.c2.hdr.tid is the request tid and tx.c2.data is registered.
- Back-to-back reads yield back-to-back responses.

Writes:
- Take effect at the clock edge of the request cycle; a read in cycle N+1 sees the new value.

FIFO:
- Show-ahead: the head is valid combinationally whenever not empty.
- POP captures the head and advances the read pointer on the same edge.
- STATUS read in the same cycle as a POP cannot occur (one request/cycle).
- A STATUS read at N+1 reflects the pop.

Full/empty:
- full = (count == DEPTH).
- empty = (count == 0).
- Both are derived from the registered count.

Reset mid-operation:
- Asynchronous clear of all state.
- Any in-flight response is discarded: mmioRdValid drops immediately.

## Structure
- Package mmio_afu_pkg holds the address constants (DFH, AFU_ID_L/H, USER_BASE, FIFO_PUSH, FIFO_POP, FIFO_STATUS, FIFO_PEEK, FIFO_CTRL), the CTRL bit indices and the STATUS bit positions.
- Sub-module mmio_fifo (params DATA_W, DEPTH) provides:
  - Ports: clk, rst, push, pop, flush, din, dout (show-ahead), count, full, empty.
  - Behaviour: internal wrapping pointers; ignores push when full and pop when empty; flush takes priority over push/pop.
- The top level decodes MMIO, owns the user registers and flags, and registers the tx.c2 response.

## Test plan
- Reset, then read 0x0000, 0x0046 → DFH = 64'h1000_0100_0000_0000; STATUS = 0x1 (empty); tid echoed; response exactly one cycle after request.
- Write 0xDEADBEEF_00000001 to 0x0022, read 0x0022 and 0x0020 → 0xDEADBEEF_00000001 and 0.
- DEPTH=16: push 1..16, STATUS → count=16, full=1; push 17 → overflow=1 and contents unchanged; then pop 16 times → 1..16 in order; STATUS → empty=1, overflow=1.
- Empty FIFO: POP → 0, underflow=1; write CTRL=0x2 → STATUS = 0x1.
- Wrap-around: push 10, pop 10, push 12 values 0xA0.., PEEK → 0xA0 twice; count unchanged; pop 12 → 0xA0..0xAB in order.
- Push 5, write CTRL=0x1 → STATUS empty.
- Push 3, assert rst during an outstanding read → no mmioRdValid; STATUS after reset = 0x1.
- DATA_W=8 build: push 0x1234 → POP returns 0x34.

Source files
------------

// File: rtl/mmio_afu_pkg.sv
// Shared CCI-P type slice, MMIO address map and CTRL/STATUS bit positions for the MMIO FIFO AFU.
// Only the CCI-P fields this AFU touches are modelled; widths follow the platform definitions.
package mmio_afu_pkg;

  typedef logic [15:0] t_ccip_mmioAddr;
  typedef logic [8:0]  t_ccip_tid;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef logic [27:0] t_ccip_c0_RspMemHdr;
  typedef logic [27:0] t_ccip_c1_RspMemHdr;
  typedef logic [73:0] t_ccip_c0_ReqMemHdr;
  typedef logic [79:0] t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  // 32-bit word addresses; every register is 64-bit and sits on an even address
  localparam t_ccip_mmioAddr DFH         = 16'h0000;
  localparam t_ccip_mmioAddr AFU_ID_L    = 16'h0002;
  localparam t_ccip_mmioAddr AFU_ID_H    = 16'h0004;
  localparam t_ccip_mmioAddr USER_BASE   = 16'h0020;
  localparam t_ccip_mmioAddr FIFO_PUSH   = 16'h0040;
  localparam t_ccip_mmioAddr FIFO_CTRL   = 16'h0042;
  localparam t_ccip_mmioAddr FIFO_POP    = 16'h0044;
  localparam t_ccip_mmioAddr FIFO_STATUS = 16'h0046;
  localparam t_ccip_mmioAddr FIFO_PEEK   = 16'h0048;

  localparam logic [63:0]  DFH_VALUE    = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};
  localparam logic [127:0] AFU_ID_VALUE = 128'h9D73_E8F2_58E1_4D2B_9E5A_3C1F_0B7A_6E44;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  localparam int STS_EMPTY   = 0;
  localparam int STS_FULL    = 1;
  localparam int STS_UDF     = 2;
  localparam int STS_OVF     = 3;
  localparam int STS_CNT_LSB = 4;

  function automatic t_ccip_mmioAddr user_addr(input int unsigned idx);
    return USER_BASE + 16'(2 * idx);
  endfunction

endpackage

// File: rtl/mmio_fifo_afu_if.sv
// CCI-P receive/transmit pair as seen by the AFU; slave = AFU side, master = platform shim side.
interface mmio_fifo_afu_if;
  import mmio_afu_pkg::*;

  t_if_ccip_Rx rx;
  t_if_ccip_Tx tx;

  modport slave  (input rx, output tx);
  modport master (output rx, input tx);

endinterface

// File: rtl/mmio_fifo.sv
// Show-ahead FIFO: head valid combinationally while not empty, push/pop applied on the clock edge.
// No backpressure port; push when full and pop when empty are silently ignored, flush wins over both.
module mmio_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage carries no reset: entries are only observable once count covers them
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/mmio_fifo_afu.sv
// MMIO AFU: DFH/AFU_ID, user registers and a host-driven show-ahead FIFO with sticky error flags.
// Writes land on the request edge; read responses appear exactly one cycle after the request, no stalls.
module mmio_fifo_afu
  import mmio_afu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int NUM_REGS = 4
) (
  input  logic            clk,
  input  logic            rst,
  mmio_fifo_afu_if.slave  ccip
);

  localparam int CW = $clog2(DEPTH) + 1;

  t_ccip_c0_ReqMmioHdr w_hdr;
  t_ccip_mmioAddr      w_addr;
  logic [63:0]         w_wdat;
  logic                w_wr;
  logic                w_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_ctrl;
  logic                w_flush;
  logic                w_clr;
  logic [DATA_W-1:0]   w_dout;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic [63:0]         w_head_ext;
  logic [63:0]         w_status;
  logic [63:0]         w_rdata;
  t_if_ccip_Tx         w_tx;
  logic                w_unused;

  logic [63:0]         r_user [NUM_REGS];
  logic                r_ovf;
  logic                r_udf;
  logic                r_rd_vld;
  t_ccip_tid           r_rd_tid;
  logic [63:0]         r_rd_dat;

  assign w_hdr  = t_ccip_c0_ReqMmioHdr'(ccip.rx.c0.hdr);
  assign w_addr = w_hdr.address;
  assign w_wdat = ccip.rx.c0.data[63:0];
  assign w_wr   = ccip.rx.c0.mmioWrValid;
  // A read colliding with a write is dropped; the write is serviced
  assign w_rd   = ccip.rx.c0.mmioRdValid && !ccip.rx.c0.mmioWrValid;

  assign w_push  = w_wr && (w_addr == FIFO_PUSH);
  assign w_ctrl  = w_wr && (w_addr == FIFO_CTRL);
  assign w_flush = w_ctrl && w_wdat[CTRL_FLUSH_BIT];
  assign w_clr   = w_ctrl && w_wdat[CTRL_CLR_BIT];
  assign w_pop   = w_rd && (w_addr == FIFO_POP);

  mmio_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_wdat[DATA_W-1:0]),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_push && w_full) r_ovf <= 1'b1;
      if (w_pop && w_empty) r_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_user[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr && (w_addr == user_addr(i))) r_user[i] <= w_wdat;
      end
    end
  end

  always_comb begin
    w_head_ext = '0;
    if (!w_empty) w_head_ext[DATA_W-1:0] = w_dout;
  end

  always_comb begin
    w_status = '0;
    w_status[STS_CNT_LSB +: CW] = w_count;
    w_status[STS_OVF]           = r_ovf;
    w_status[STS_UDF]           = r_udf;
    w_status[STS_FULL]          = w_full;
    w_status[STS_EMPTY]         = w_empty;
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      DFH:         w_rdata = DFH_VALUE;
      AFU_ID_L:    w_rdata = AFU_ID_VALUE[63:0];
      AFU_ID_H:    w_rdata = AFU_ID_VALUE[127:64];
      FIFO_POP:    w_rdata = w_head_ext;
      FIFO_PEEK:   w_rdata = w_head_ext;
      FIFO_STATUS: w_rdata = w_status;
      default: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_addr == user_addr(i)) w_rdata = r_user[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_tid <= '0;
      r_rd_dat <= '0;
    end else begin
      r_rd_vld <= w_rd;
      if (w_rd) begin
        r_rd_tid <= w_hdr.tid;
        r_rd_dat <= w_rdata;
      end
    end
  end

  always_comb begin
    w_tx                = '0;
    w_tx.c2.hdr.tid     = r_rd_tid;
    w_tx.c2.mmioRdValid = r_rd_vld;
    w_tx.c2.data        = r_rd_dat;
  end

  assign ccip.tx = w_tx;

  assign w_unused = ^{ccip.rx.c0TxAlmFull, ccip.rx.c1TxAlmFull, ccip.rx.c1,
                      ccip.rx.c0.rspValid, w_hdr.length, w_hdr.rsvd,
                      ccip.rx.c0.data[511:64], w_wdat};

endmodule

// File: tb/tb_mmio_fifo_afu.sv
// Directed bench for mmio_fifo_afu: a DEPTH=16/64-bit instance plus an 8-bit instance sharing the same rx.
module tb_mmio_fifo_afu;
  import mmio_afu_pkg::*;

  localparam logic [15:0] A_DFH    = 16'h0000;
  localparam logic [15:0] A_IDL    = 16'h0002;
  localparam logic [15:0] A_IDH    = 16'h0004;
  localparam logic [15:0] A_RSV6   = 16'h0006;
  localparam logic [15:0] A_USER0  = 16'h0020;
  localparam logic [15:0] A_USER1  = 16'h0022;
  localparam logic [15:0] A_USER2  = 16'h0024;
  localparam logic [15:0] A_PUSH   = 16'h0040;
  localparam logic [15:0] A_CTRL   = 16'h0042;
  localparam logic [15:0] A_POP    = 16'h0044;
  localparam logic [15:0] A_STATUS = 16'h0046;
  localparam logic [15:0] A_PEEK   = 16'h0048;

  localparam logic [63:0] EXP_DFH  = 64'h1000_0100_0000_0000;
  localparam logic [63:0] EXP_IDL  = 64'h9E5A_3C1F_0B7A_6E44;
  localparam logic [63:0] EXP_IDH  = 64'h9D73_E8F2_58E1_4D2B;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [8:0]  tid_ctr;
  logic [63:0] rsp_dat;
  logic        rsp_vld;
  logic [8:0]  rsp_tid;
  logic [63:0] n_rsp_dat;

  mmio_fifo_afu_if ifm ();
  mmio_fifo_afu_if ifn ();

  assign ifn.rx = ifm.rx;

  mmio_fifo_afu #(.DATA_W(64), .DEPTH(16), .NUM_REGS(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .ccip (ifm.slave)
  );

  mmio_fifo_afu #(.DATA_W(8), .DEPTH(16), .NUM_REGS(4)) u_dut_n8 (
    .clk  (clk),
    .rst  (rst),
    .ccip (ifn.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic rd, input logic [15:0] addr,
                           input logic [8:0] tid, input logic [63:0] dat);
    t_ccip_c0_ReqMmioHdr h;
    h         = '0;
    h.address = addr;
    h.tid     = tid;
    ifm.rx                = '0;
    ifm.rx.c0.hdr         = h;
    ifm.rx.c0.data        = 512'(dat);
    ifm.rx.c0.mmioWrValid = wr;
    ifm.rx.c0.mmioRdValid = rd;
  endtask

  // Request presented for one cycle; response sampled at the following falling edge
  task automatic req(input logic wr, input logic rd, input logic [15:0] addr, input logic [63:0] dat);
    @(negedge clk);
    drive_req(wr, rd, addr, tid_ctr, dat);
    @(negedge clk);
    ifm.rx    = '0;
    rsp_vld   = ifm.tx.c2.mmioRdValid;
    rsp_dat   = ifm.tx.c2.data;
    rsp_tid   = ifm.tx.c2.hdr.tid;
    n_rsp_dat = ifn.tx.c2.data;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] dat);
    req(1'b1, 1'b0, addr, dat);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [63:0] exp);
    tid_ctr = tid_ctr + 9'd1;
    req(1'b0, 1'b1, addr, 64'h0);
    chk({tag, "_vld"}, 64'(rsp_vld), 64'd1);
    chk(tag, rsp_dat, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    tid_ctr  = 9'd0;
    rst      = 1'b1;
    ifm.rx   = '0;
    #3;
    chk("rst_rdvld",  64'(ifm.tx.c2.mmioRdValid), 64'd0);
    chk("rst_data",   ifm.tx.c2.data, 64'd0);
    chk("rst_tid",    64'(ifm.tx.c2.hdr.tid), 64'd0);
    chk("rst_c0c1",   64'({ifm.tx.c0.valid, ifm.tx.c1.valid}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // DFH with exact one-cycle response window and tid echo
    @(negedge clk);
    drive_req(1'b0, 1'b1, A_DFH, 9'h15A, 64'h0);
    chk("dfh_pre_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd0);
    @(negedge clk);
    ifm.rx = '0;
    chk("dfh_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd1);
    chk("dfh_tid", 64'(ifm.tx.c2.hdr.tid), 64'h15A);
    chk("dfh_dat", ifm.tx.c2.data, EXP_DFH);
    @(negedge clk);
    chk("dfh_post_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd0);

    // Back-to-back reads give back-to-back responses
    @(negedge clk);
    drive_req(1'b0, 1'b1, A_IDL, 9'h011, 64'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, A_IDH, 9'h022, 64'h0);
    chk("b2b0_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd1);
    chk("b2b0_tid", 64'(ifm.tx.c2.hdr.tid), 64'h011);
    chk("b2b0_dat", ifm.tx.c2.data, EXP_IDL);
    @(negedge clk);
    ifm.rx = '0;
    chk("b2b1_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd1);
    chk("b2b1_tid", 64'(ifm.tx.c2.hdr.tid), 64'h022);
    chk("b2b1_dat", ifm.tx.c2.data, EXP_IDH);

    rd_chk("status_rst", A_STATUS, 64'h1);
    rd_chk("unlisted",   A_RSV6,   64'h0);

    // Narrow instance truncates on push and zero-extends on pop
    wr(A_PUSH, 64'h1234);
    rd_chk("pop_w64", A_POP, 64'h1234);
    chk("pop_w8", n_rsp_dat, 64'h34);
    rd_chk("status_after_w", A_STATUS, 64'h1);

    wr(A_USER1, 64'hDEAD_BEEF_0000_0001);
    rd_chk("user1", A_USER1, 64'hDEAD_BEEF_0000_0001);
    rd_chk("user0", A_USER0, 64'h0);

    // Simultaneous write and read: write lands, read is dropped
    req(1'b1, 1'b1, A_USER2, 64'h5555_AAAA_0000_FFFF);
    chk("wrrd_no_rsp", 64'(rsp_vld), 64'd0);
    rd_chk("user2", A_USER2, 64'h5555_AAAA_0000_FFFF);

    // Fill, overflow, drain
    for (int i = 1; i <= 16; i++) wr(A_PUSH, 64'(i));
    rd_chk("status_full", A_STATUS, 64'h102);
    wr(A_PUSH, 64'd17);
    rd_chk("status_ovf", A_STATUS, 64'h10A);
    rd_chk("peek_full", A_PEEK, 64'd1);
    for (int i = 1; i <= 16; i++) rd_chk("pop_seq", A_POP, 64'(i));
    rd_chk("status_drained", A_STATUS, 64'h9);

    // Underflow then sticky clear
    rd_chk("pop_empty", A_POP, 64'h0);
    rd_chk("status_udf", A_STATUS, 64'hD);
    wr(A_CTRL, 64'h2);
    rd_chk("status_clr", A_STATUS, 64'h1);

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) wr(A_PUSH, 64'(i + 100));
    for (int i = 0; i < 10; i++) rd_chk("pop_pre_wrap", A_POP, 64'(i + 100));
    for (int i = 0; i < 12; i++) wr(A_PUSH, 64'(i + 'hA0));
    rd_chk("peek0", A_PEEK, 64'hA0);
    rd_chk("peek1", A_PEEK, 64'hA0);
    rd_chk("status_wrap", A_STATUS, 64'hC0);
    for (int i = 0; i < 12; i++) rd_chk("pop_wrap", A_POP, 64'(i + 'hA0));
    rd_chk("status_wrap_done", A_STATUS, 64'h1);

    // Flush
    for (int i = 0; i < 5; i++) wr(A_PUSH, 64'(i + 7));
    rd_chk("status_five", A_STATUS, 64'h50);
    wr(A_CTRL, 64'h1);
    rd_chk("status_flush", A_STATUS, 64'h1);
    rd_chk("peek_flush", A_PEEK, 64'h0);

    // Reset while a response is on the bus
    for (int i = 0; i < 3; i++) wr(A_PUSH, 64'(i + 1));
    @(negedge clk);
    drive_req(1'b0, 1'b1, A_STATUS, 9'h033, 64'h0);
    @(posedge clk);
    #2;
    chk("inflight_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_vld", 64'(ifm.tx.c2.mmioRdValid), 64'd0);
    @(negedge clk);
    ifm.rx = '0;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("status_post_rst", A_STATUS, 64'h1);
    rd_chk("user1_post_rst", A_USER1, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
